// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The FSM state encodes which master held the port on the previous cycle.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        LOCK1 = 2'd3
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam int MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the CPU stall line and the data-memory port.
// Handshake: a master holds req (with wr/addr/wdata stable) until it sees gnt in the same cycle;
// a read's data is returned one cycle after its grant with rvalid, and there is no backpressure.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          cpu_stall;

    logic          m1_req;
    logic          m1_wr;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, cpu_stall,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, cpu_stall,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not granted last.
module dmem_rr_pick
    import cpu_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_t last,
    output logic    gnt0,
    output logic    gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | (last == M1));
        gnt1 = req1 & (~req0 | (last == M0));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage (m0) and a peripheral/DMA master (m1)
// with bounded m1 lock bursts and registered read-data return.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    dmem_arbiter_if.slave                      bus,
    output arb_state_t                         dbg_state,
    output logic [$clog2(MAX_BURST+1)-1:0]     dbg_burst_cnt
);

    localparam int             CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BURST);

    arb_state_t    state, state_nxt;
    master_t       last, last_nxt;
    logic [CW-1:0] burst_cnt, burst_nxt;
    logic          rv0, rv1;
    logic          pick0, pick1;
    logic          hold_lock;
    logic          gnt0, gnt1;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    dmem_rr_pick u_pick (
        .req0 (bus.m0_req),
        .req1 (bus.m1_req),
        .last (last),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= M1;
            burst_cnt <= '0;
            rv0       <= 1'b0;
            rv1       <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            rv0       <= gnt0 & ~bus.m0_wr;
            rv1       <= gnt1 & ~bus.m1_wr;
        end
    end

    // Grants are forced low while reset is held so no strobe escapes during reset.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = IDLE;
        last_nxt  = last;
        burst_nxt = '0;
        hold_lock = (state == LOCK1) && bus.m1_req && bus.m1_lock && (burst_cnt < MAX_CNT);
        if (reset) begin
            if (hold_lock) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
        end
        if (gnt0) begin
            state_nxt = OWN0;
            last_nxt  = M0;
        end else if (gnt1) begin
            last_nxt = M1;
            if (bus.m1_lock) begin
                state_nxt = LOCK1;
                burst_nxt = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + 1'b1;
            end else begin
                state_nxt = OWN1;
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        if (gnt0) begin
            addr_sel  = bus.m0_addr;
            wdata_sel = bus.m0_wdata;
        end else if (gnt1) begin
            addr_sel  = bus.m1_addr;
            wdata_sel = bus.m1_wdata;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.cpu_stall = bus.m0_req & ~gnt0 & reset;
    assign bus.mem_rd    = (gnt0 & ~bus.m0_wr) | (gnt1 & ~bus.m1_wr);
    assign bus.mem_wr    = (gnt0 & bus.m0_wr) | (gnt1 & bus.m1_wr);
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_rdata  = rv0 ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = rv1 ? bus.mem_rdata : '0;

    assign dbg_state     = state;
    assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_dmem_arbiter;
    import cpu_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       reset;
    arb_state_t dbg_state;
    logic [3:0] dbg_burst_cnt;
    int         n_vec;
    int         n_err;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.MAX_BURST(MAXB), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    // Data memory: writes land at the edge, read data appears one cycle after mem_rd.
    logic [DW-1:0] tb_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'h5A00_1357 ^ (a * 32'h0001_0203);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd)
            bus.mem_rdata <= tb_mem.exists(bus.mem_addr) ? tb_mem[bus.mem_addr] : init_val(bus.mem_addr);
        if (bus.mem_wr)
            tb_mem[bus.mem_addr] = bus.mem_wdata;
    end

    // Reference model: previous winner, lock run length, shadow memory, pending read data.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q [$];
    int            m_last, m_cnt, rv_who, g;
    bit            m_locked;
    logic          exp_g0, exp_g1, exp_mrd, exp_mwr, exp_stall, exp_rv0, exp_rv1;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rd0, exp_rd1;

    task model_reset;
        m_last   = 1;
        m_cnt    = 0;
        m_locked = 0;
        rv_who   = -1;
        exp_q.delete();
    endtask

    task model_eval;
        g = -1;
        if (reset) begin
            if (m_locked && bus.m1_req && bus.m1_lock && m_cnt < MAXB) g = 1;
            else if (bus.m0_req && bus.m1_req)                          g = 1 - m_last;
            else if (bus.m0_req)                                        g = 0;
            else if (bus.m1_req)                                        g = 1;
        end
        exp_g0    = (g == 0);
        exp_g1    = (g == 1);
        exp_mrd   = (g == 0) ? !bus.m0_wr : (g == 1) ? !bus.m1_wr : 1'b0;
        exp_mwr   = (g == 0) ? bus.m0_wr  : (g == 1) ? bus.m1_wr  : 1'b0;
        exp_addr  = (g == 0) ? bus.m0_addr  : (g == 1) ? bus.m1_addr  : '0;
        exp_wdata = (g == 0) ? bus.m0_wdata : (g == 1) ? bus.m1_wdata : '0;
        exp_stall = reset && bus.m0_req && (g != 0);
        exp_rv0   = (rv_who == 0);
        exp_rv1   = (rv_who == 1);
        exp_rd0   = (exp_rv0 && exp_q.size() > 0) ? exp_q[0] : '0;
        exp_rd1   = (exp_rv1 && exp_q.size() > 0) ? exp_q[0] : '0;
    endtask

    task model_commit;
        if (rv_who >= 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        rv_who = -1;
        if (g >= 0) begin
            m_locked = (g == 1) && bus.m1_lock;
            m_cnt    = m_locked ? m_cnt + 1 : 0;
            m_last   = g;
            if (exp_mrd) begin
                exp_q.push_back(ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : init_val(exp_addr));
                rv_who = g;
            end
            if (exp_mwr) ref_mem[exp_addr] = exp_wdata;
        end else begin
            m_locked = 0;
            m_cnt    = 0;
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input bit l1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1);
        bus.m0_req   = r0;
        bus.m0_wr    = w0;
        bus.m0_addr  = a0;
        bus.m0_wdata = d0;
        bus.m1_req   = r1;
        bus.m1_wr    = w1;
        bus.m1_lock  = l1;
        bus.m1_addr  = a1;
        bus.m1_wdata = d1;
        #1;
        model_eval();
    endtask

    task idle;
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task tick;
        model_commit();
        @(negedge clk);
    endtask

    task apply_reset;
        reset = 1'b0;
        model_reset();
        idle();
        tick();
        idle();
        tick();
        reset = 1'b1;
        idle();
        tick();
    endtask

    task test_reset;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h10, '0, 1, 1, 1, 32'h20, 32'h1);
            n_vec++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.m0_rvalid, bus.m1_rvalid} !== 7'b0
                || bus.m0_rdata !== '0 || bus.m1_rdata !== '0 || dbg_state !== IDLE || dbg_burst_cnt !== 4'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: gnt %b%b rd %b wr %b stall %b rv %b%b state %0d cnt %0d, need all 0",
                         i, bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.m0_rvalid,
                         bus.m1_rvalid, dbg_state, dbg_burst_cnt);
            end
            tick();
        end
        reset = 1'b1;
        idle();
        n_vec++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall} !== 5'b0 || bus.mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_release_idle: gnt %b%b rd %b wr %b addr %h, need 0",
                     bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr);
        end
        tick();
    endtask

    task test_single_read;
        drive(1, 0, 32'h10, '0, 0, 0, 0, '0, '0);
        n_vec++;
        if (bus.m0_gnt !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 32'h10
            || bus.cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL single_read_gnt: gnt %b rd %b wr %b addr %h stall %b, need 1 1 0 00000010 0",
                     bus.m0_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.cpu_stall);
        end
        tick();
        idle();
        n_vec++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== init_val(32'h10) || bus.m1_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL single_read_data: rvalid %b rdata %h m1_rvalid %b, need 1 %h 0",
                     bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, init_val(32'h10));
        end
        tick();
        idle();
        n_vec++;
        if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== '0) begin
            n_err++;
            $display("FAIL single_read_rvalid_drop: rvalid %b rdata %h, need 0 0", bus.m0_rvalid, bus.m0_rdata);
        end
        tick();
    endtask

    task test_tie;
        logic e0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h10, '0, 1, 0, 0, 32'h14, '0);
            e0 = (i % 2 == 0);
            n_vec++;
            if (bus.m0_gnt !== e0 || bus.m1_gnt !== ~e0 || bus.cpu_stall !== ~e0) begin
                n_err++;
                $display("FAIL tie_rr cyc%0d: gnt %b%b stall %b, need %b%b %b",
                         i + 1, bus.m0_gnt, bus.m1_gnt, bus.cpu_stall, e0, ~e0, ~e0);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task test_burst;
        int   m1_sent;
        bit   m0_done;
        logic e1;
        apply_reset();
        m1_sent = 0;
        m0_done = 0;
        for (int i = 0; i < 13; i++) begin
            drive((i >= 1) && !m0_done, 1, 32'h200, $urandom, m1_sent < 12, 1, 1, 32'h100 + 4 * m1_sent, $urandom);
            e1 = (i != 8);
            n_vec++;
            if (bus.m1_gnt !== e1 || bus.m0_gnt !== ~e1 || bus.mem_wr !== 1'b1) begin
                n_err++;
                $display("FAIL burst_gnt cyc%0d: gnt %b%b wr %b, need %b%b 1",
                         i + 1, bus.m0_gnt, bus.m1_gnt, bus.mem_wr, ~e1, e1);
            end
            if (i == 8 || i == 9) begin
                n_vec++;
                if (dbg_burst_cnt !== ((i == 8) ? 4'd8 : 4'd0)) begin
                    n_err++;
                    $display("FAIL burst_cnt cyc%0d: cnt %0d, need %0d", i + 1, dbg_burst_cnt, (i == 8) ? 8 : 0);
                end
            end
            if (g == 1) m1_sent++;
            if (g == 0) m0_done = 1;
            tick();
        end
        idle();
        tick();
    endtask

    task test_wr_rd;
        drive(1, 1, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, '0, '0);
        n_vec++;
        if (bus.m0_gnt !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wr_rd_write: gnt %b wr %b wdata %h, need 1 1 deadbeef",
                     bus.m0_gnt, bus.mem_wr, bus.mem_wdata);
        end
        tick();
        drive(0, 0, '0, '0, 1, 0, 0, 32'h20, '0);
        n_vec++;
        if (bus.m1_gnt !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h20) begin
            n_err++;
            $display("FAIL wr_rd_read: gnt %b rd %b addr %h, need 1 1 00000020", bus.m1_gnt, bus.mem_rd, bus.mem_addr);
        end
        tick();
        idle();
        n_vec++;
        if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hDEAD_BEEF || bus.m0_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rd_data: m1 rvalid %b rdata %h m0 rvalid %b, need 1 deadbeef 0",
                     bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid);
        end
        tick();
    endtask

    task test_reset_mid;
        drive(0, 0, '0, '0, 1, 0, 0, 32'h30, '0);
        n_vec++;
        if (bus.m1_gnt !== 1'b1 || bus.mem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_gnt: m1_gnt %b rd %b, need 1 1", bus.m1_gnt, bus.mem_rd);
        end
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h34, '0, 1, 0, 0, 32'h30, '0);
            n_vec++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.m0_rvalid, bus.m1_rvalid} !== 7'b0
                || bus.mem_addr !== '0 || bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
                n_err++;
                $display("FAIL rstmid_held cyc%0d: gnt %b%b rd %b stall %b rv %b%b addr %h, need all 0",
                         i, bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.cpu_stall, bus.m0_rvalid, bus.m1_rvalid,
                         bus.mem_addr);
            end
            tick();
        end
        reset = 1'b1;
        drive(1, 0, 32'h34, '0, 1, 0, 0, 32'h30, '0);
        n_vec++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_first_tie: gnt %b%b m1_rvalid %b, need 10 0", bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid);
        end
        tick();
        idle();
        n_vec++;
        if (bus.m1_rvalid !== 1'b0 || bus.m0_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_rvalid: m1 %b m0 %b, need 0 1", bus.m1_rvalid, bus.m0_rvalid);
        end
        tick();
    endtask

    task test_idle;
        drive(0, 0, '0, '0, 1, 1, 1, 32'h60, $urandom);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) begin
                n_vec++;
                if (dbg_state !== LOCK1 || dbg_burst_cnt !== 4'd1) begin
                    n_err++;
                    $display("FAIL idle_after_lock: state %0d cnt %0d, need %0d 1", dbg_state, dbg_burst_cnt, LOCK1);
                end
            end
            n_vec++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall} !== 5'b0) begin
                n_err++;
                $display("FAIL idle_strobes cyc%0d: gnt %b%b rd %b wr %b stall %b, need 0",
                         i, bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall);
            end
            tick();
        end
        idle();
        n_vec++;
        if (dbg_state !== IDLE || dbg_burst_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL idle_state: state %0d cnt %0d, need %0d 0", dbg_state, dbg_burst_cnt, IDLE);
        end
        tick();
    endtask

    task test_random;
        bit lk;
        bit r1;
        lk = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) lk = ~lk;
            r1 = lk ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 32'h40 + 4 * $urandom_range(0, 7), $urandom,
                  r1, 1'($urandom_range(0, 1)), lk, 32'h40 + 4 * $urandom_range(0, 7), $urandom);
            n_vec++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.m0_rvalid, bus.m1_rvalid}
                    !== {exp_g0, exp_g1, exp_mrd, exp_mwr, exp_stall, exp_rv0, exp_rv1}
                || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata
                || bus.m0_rdata !== exp_rd0 || bus.m1_rdata !== exp_rd1) begin
                n_err++;
                $display("FAIL random cyc%0d: ctl %b need %b addr %h need %h wdata %h need %h rd0 %h need %h rd1 %h need %h",
                         i, {bus.m0_gnt, bus.m1_gnt, bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.m0_rvalid,
                         bus.m1_rvalid}, {exp_g0, exp_g1, exp_mrd, exp_mwr, exp_stall, exp_rv0, exp_rv1},
                         bus.mem_addr, exp_addr, bus.mem_wdata, exp_wdata, bus.m0_rdata, exp_rd0,
                         bus.m1_rdata, exp_rd1);
            end
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        model_reset();
        test_reset();
        test_single_read();
        test_tie();
        test_burst();
        test_wr_rd();
        test_reset_mid();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
